// File: rtl/affine_seq_pkg.sv
// affine_seq shared types and constants.
// State encoding, saturation bounds and accumulator width.
package affine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    WAIT,
    DONE
  } state_t;

  localparam int FRAC_DEFAULT = 7;
  localparam int SAT_MAX      = 127;
  localparam int SAT_MIN      = -128;
  localparam int ACC_W        = 11;

endpackage

// File: rtl/affine_seq_sat8.sv
// Clamp an accumulator value to the signed 8-bit range.
// Pure combinational; used once per output channel.
module sat8
  import affine_pkg::*;
(
  input  logic [ACC_W-1:0] i_d,
  output logic [7:0]       o_q
);

  logic signed [ACC_W-1:0] w_d;

  assign w_d = $signed(i_d);

  // clamp to [SAT_MIN, SAT_MAX], else pass low byte
  always_comb begin
    o_q = w_d[7:0];
    if (w_d > SAT_MAX) begin
      o_q = 8'(SAT_MAX);
    end else if (w_d < SAT_MIN) begin
      o_q = 8'(SAT_MIN);
    end
  end

endmodule

// File: rtl/mult.sv
// Shared signed multiplier, low W bits of the product.
// P=1 registers the product, adding one cycle of latency.
module mult #(
  parameter int W = 16,
  parameter int P = 0
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Prod
);

  logic [W-1:0] w_prod;
  logic [W-1:0] r_prod;

  assign w_prod = W'($signed(A) * $signed(B));

  // optional product pipeline register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_prod <= '0;
    end else begin
      r_prod <= w_prod;
    end
  end

  assign Prod = (P != 0) ? r_prod : w_prod;

endmodule

// File: rtl/affine_seq.sv
// Multi-cycle affine transform on one shared multiplier.
// Four products accumulate into two saturated 8-bit results.
module affine_seq
  import affine_pkg::*;
#(
  parameter int P    = 0,
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Start,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  input  logic [7:0] A11,
  input  logic [7:0] A12,
  input  logic [7:0] A21,
  input  logic [7:0] A22,
  input  logic [7:0] B1,
  input  logic [7:0] B2,
  input  logic       Ack,
  output logic       Busy,
  output logic       Valid,
  output logic [7:0] Xo,
  output logic [7:0] Yo
);

  state_t           r_state;
  logic [1:0]       r_step;
  logic [7:0]       r_x;
  logic [7:0]       r_y;
  logic [7:0]       r_a11;
  logic [7:0]       r_a12;
  logic [7:0]       r_a21;
  logic [7:0]       r_a22;
  logic [ACC_W-1:0] r_acc1;
  logic [ACC_W-1:0] r_acc2;
  logic             r_valid;
  logic [7:0]       r_xo;
  logic [7:0]       r_yo;

  logic [7:0]       w_coef;
  logic [7:0]       w_var;
  logic [15:0]      w_opa;
  logic [15:0]      w_opb;
  logic [15:0]      w_prod;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_acc1_nxt;
  logic [ACC_W-1:0] w_acc2_nxt;
  logic [7:0]       w_sat1;
  logic [7:0]       w_sat2;
  logic             w_acc_en;
  logic             w_last;

  // step selects which coefficient/variable pair feeds the multiplier
  always_comb begin
    w_coef = r_a11;
    w_var  = r_x;
    case (r_step)
      2'd0: begin w_coef = r_a11; w_var = r_x; end
      2'd1: begin w_coef = r_a12; w_var = r_y; end
      2'd2: begin w_coef = r_a21; w_var = r_x; end
      default: begin w_coef = r_a22; w_var = r_y; end
    endcase
  end

  assign w_opa = {{8{w_coef[7]}}, w_coef};
  assign w_opb = {{8{w_var[7]}}, w_var};

  mult #(
    .W(16),
    .P(P)
  ) u_mult (
    .Clock (Clock),
    .nReset(nReset),
    .A     (w_opa),
    .B     (w_opb),
    .Prod  (w_prod)
  );

  assign w_term     = ACC_W'($signed(w_prod) >>> FRAC);
  assign w_acc1_nxt = r_acc1 + w_term;
  assign w_acc2_nxt = r_acc2 + w_term;
  assign w_last     = (r_step == 2'd3);
  assign w_acc_en   = (r_state == WAIT) ||
                      ((P == 0) && (r_state == MUL));

  sat8 u_sat_x (
    .i_d(r_acc1),
    .o_q(w_sat1)
  );

  sat8 u_sat_y (
    .i_d(w_acc2_nxt),
    .o_q(w_sat2)
  );

  // control FSM with operand latches, accumulators and result registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_a11   <= '0;
      r_a12   <= '0;
      r_a21   <= '0;
      r_a22   <= '0;
      r_acc1  <= '0;
      r_acc2  <= '0;
      r_valid <= 1'b0;
      r_xo    <= '0;
      r_yo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_x     <= X;
            r_y     <= Y;
            r_a11   <= A11;
            r_a12   <= A12;
            r_a21   <= A21;
            r_a22   <= A22;
            r_acc1  <= {{(ACC_W-8){B1[7]}}, B1};
            r_acc2  <= {{(ACC_W-8){B2[7]}}, B2};
            r_step  <= '0;
            r_state <= MUL;
          end
        end
        MUL, WAIT: begin
          if (w_acc_en) begin
            if (r_step[1]) begin
              r_acc2 <= w_acc2_nxt;
            end else begin
              r_acc1 <= w_acc1_nxt;
            end
            r_step <= r_step + 2'd1;
            if (w_last) begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_xo    <= w_sat1;
              r_yo    <= w_sat2;
            end else begin
              r_state <= MUL;
            end
          end else begin
            r_state <= WAIT;
          end
        end
        DONE: begin
          if (Ack) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Busy  = (r_state != IDLE);
  assign Valid = r_valid;
  assign Xo    = r_xo;
  assign Yo    = r_yo;

endmodule

// File: tb/tb_affine_seq.sv
// Self-checking bench for affine_seq, P=0 and P=1 builds.
// Random vectors are compared with an arithmetic reference model.
module tb_affine_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] x, y, a11, a12, a21, a22, b1, b2;
  logic       st0, st1, ack0, ack1;
  logic       busy0, val0, busy1, val1;
  logic [7:0] xo0, yo0, xo1, yo1;

  int total = 0;
  int bad   = 0;

  int vx, vy, v11, v12, v21, v22, vb1, vb2;
  int ex, ey, k;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  affine_seq #(.P(0)) u_dut0 (
    .Clock(clk), .nReset(rst_n), .Start(st0),
    .X(x), .Y(y), .A11(a11), .A12(a12), .A21(a21), .A22(a22),
    .B1(b1), .B2(b2), .Ack(ack0),
    .Busy(busy0), .Valid(val0), .Xo(xo0), .Yo(yo0)
  );

  affine_seq #(.P(1)) u_dut1 (
    .Clock(clk), .nReset(rst_n), .Start(st1),
    .X(x), .Y(y), .A11(a11), .A12(a12), .A21(a21), .A22(a22),
    .B1(b1), .B2(b2), .Ack(ack1),
    .Busy(busy1), .Valid(val1), .Xo(xo1), .Yo(yo1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv128(input int p);
    int q;
    q = p / 128;
    if (p < 0 && q * 128 != p) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model();
    ex = clamp(vb1 + fdiv128(v11 * vx) + fdiv128(v12 * vy));
    ey = clamp(vb2 + fdiv128(v21 * vx) + fdiv128(v22 * vy));
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic randv();
    vx = rnd8(); vy = rnd8();
    v11 = rnd8(); v12 = rnd8(); v21 = rnd8(); v22 = rnd8();
    vb1 = rnd8(); vb2 = rnd8();
  endtask

  task automatic setv(input int ix, input int iy,
                      input int c11, input int c12,
                      input int c21, input int c22,
                      input int o1, input int o2);
    vx = ix; vy = iy; v11 = c11; v12 = c12;
    v21 = c21; v22 = c22; vb1 = o1; vb2 = o2;
  endtask

  task automatic apply();
    x = 8'(vx); y = 8'(vy);
    a11 = 8'(v11); a12 = 8'(v12);
    a21 = 8'(v21); a22 = 8'(v22);
    b1 = 8'(vb1); b2 = 8'(vb2);
  endtask

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // pulse Start, then count edges after the sampling edge until Valid
  task automatic go(input int p, output int n);
    if (p == 0) st0 = 1'b1;
    else st1 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    st1 = 1'b0;
    n = 0;
    while (((p == 0) ? val0 : val1) !== 1'b1 && n < 30) begin
      chk("busy_run", int'((p == 0) ? busy0 : busy1), 1);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input int p, input int exx, input int exy,
                     input bit keep_ack);
    int n;
    go(p, n);
    chk((p == 0) ? "lat_p0" : "lat_p1", n, (p == 0) ? 4 : 8);
    chk("xo", (p == 0) ? sx(xo0) : sx(xo1), exx);
    chk("yo", (p == 0) ? sx(yo0) : sx(yo1), exy);
    if (p == 0) ack0 = 1'b1;
    else ack1 = 1'b1;
    @(negedge clk);
    chk("valid_drop", int'((p == 0) ? val0 : val1), 0);
    if (!keep_ack) begin
      ack0 = 1'b0;
      ack1 = 1'b0;
    end
  endtask

  task automatic nominal();
    setv(20, 40, 64, 64, 0, -128, 5, 3);
  endtask

  initial begin
    st0 = 1'b0; st1 = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
    setv(0, 0, 0, 0, 0, 0, 0, 0);
    apply();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid0", int'(val0), 0);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_xo0", sx(xo0), 0);
    chk("rst_yo0", sx(yo0), 0);
    chk("rst_valid1", int'(val1), 0);
    chk("rst_busy1", int'(busy1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    nominal();
    apply();
    model();
    chk("model_nom_x", ex, 35);
    chk("model_nom_y", ey, -37);
    go(0, k);
    chk("nom_lat", k, 4);
    chk("nom_xo", sx(xo0), 35);
    chk("nom_yo", sx(yo0), -37);
    chk("nom_busy_done", int'(busy0), 1);

    st0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      st0 = 1'b0;
      chk("hold_valid", int'(val0), 1);
      chk("hold_xo", sx(xo0), 35);
      chk("hold_yo", sx(yo0), -37);
    end
    ack0 = 1'b1;
    st0 = 1'b1;
    @(negedge clk);
    chk("ackst_valid", int'(val0), 0);
    chk("ackst_busy", int'(busy0), 0);
    chk("ackst_xo_keep", sx(xo0), 35);
    ack0 = 1'b0;
    st0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("ackst_idle", int'(busy0), 0);

    nominal();
    apply();
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    randv();
    apply();
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    k = 1;
    while (val0 !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("mulst_lat", k, 4);
    chk("mulst_xo", sx(xo0), 35);
    chk("mulst_yo", sx(yo0), -37);
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mulst_no_second", int'(busy0), 0);

    nominal();
    apply();
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", int'(val0), 0);
    chk("mrst_busy", int'(busy0), 0);
    chk("mrst_xo", sx(xo0), 0);
    chk("mrst_yo", sx(yo0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nominal();
    apply();
    run(0, 35, -37, 1'b0);

    setv(127, 127, 127, 127, 127, 127, 127, 127);
    apply();
    run(0, 127, 127, 1'b0);
    setv(127, 127, -128, -128, -128, -128, -128, -128);
    apply();
    run(0, -128, -128, 1'b0);
    setv(-1, 0, 1, 0, 0, 1, 0, 0);
    apply();
    run(0, -1, 0, 1'b0);
    setv(1, -1, 1, 0, 0, 1, 0, 0);
    apply();
    run(0, 0, -1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      randv();
      apply();
      model();
      run(0, ex, ey, 1'b0);
    end

    nominal();
    apply();
    run(1, 35, -37, 1'b0);

    ack1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      randv();
      apply();
      model();
      run(1, ex, ey, 1'b1);
      chk("b2b_idle", int'(busy1), 0);
    end
    ack1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
